// File: rtl/sum_collector_pkg.sv
// sum_collector_pkg
//   Shared definitions for the sum collector slice: collector FSM state
//   encoding, default parameter values and a small elaboration helper.
package sum_collector_pkg;

  localparam int DEF_BLOCK_LEN = 8;
  localparam int DEF_ACC_W     = 9;
  localparam int DEF_DEPTH     = 4;

  // Width of one upstream nibble sum including its carry (0..30 nominal).
  localparam int SUM_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    PUSH  = 2'd2
  } state_t;

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/sum_collector_fifo.sv
// sum_collector_fifo
//   Small result FIFO holding completed block totals.
//   Ports:
//     clk, reset      clock, asynchronous active-high reset
//     clear           synchronous flush (empties the FIFO)
//     push, push_data write request and data; ignored when full unless a
//                     pop happens in the same cycle
//     pop             read request; ignored when empty
//     pop_data        current head entry (valid while !empty)
//     full, empty     occupancy flags
module sum_collector_fifo
  import sum_collector_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [ACC_W-1:0] push_data,
  input  logic             pop,
  output logic [ACC_W-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ACC_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == (PTR_W + 1)'(DEPTH));

  // A pop frees the slot the push needs, so a full FIFO may accept a
  // write in the same cycle it is read.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr_reg] <= push_data;
  end

  assign pop_data = mem[rd_ptr_reg];

endmodule

// File: rtl/sum_collector.sv
// sum_collector
//   Accumulates BLOCK_LEN upstream nibble sums into one block total and
//   queues the totals in a DEPTH-entry FIFO for a downstream consumer.
//   Ports:
//     clk, reset          clock, asynchronous active-high reset
//     clear               synchronous flush of accumulator, counter, FIFO
//     in_valid, in_sum    upstream sample handshake / 5-bit sum
//     in_ready            collector accepts a sample this cycle
//     out_valid, out_data FIFO head handshake / block total
//     out_ready           downstream accepts the head
//     blk_cnt             samples accepted in the current block
//     fifo_full           FIFO holds DEPTH entries
module sum_collector
  import sum_collector_pkg::*;
#(
  parameter int BLOCK_LEN = DEF_BLOCK_LEN,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int DEPTH     = DEF_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         in_valid,
  input  logic [SUM_W-1:0]             in_sum,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [ACC_W-1:0]             out_data,
  input  logic                         out_ready,
  output logic [$clog2(BLOCK_LEN)-1:0] blk_cnt,
  output logic                         fifo_full
);

  localparam int CNT_W = $clog2(BLOCK_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);

  if (BLOCK_LEN < 2 || BLOCK_LEN > 16 || !is_pow2(BLOCK_LEN)) begin : g_bad_block_len
    $error("sum_collector: BLOCK_LEN must be a power of two in 2..16");
  end
  if (DEPTH < 2 || DEPTH > 8 || !is_pow2(DEPTH)) begin : g_bad_depth
    $error("sum_collector: DEPTH must be a power of two in 2..8");
  end
  if (ACC_W < SUM_W + CNT_W) begin : g_bad_acc_w
    $error("sum_collector: ACC_W too narrow to hold a full block total");
  end

  state_t           state_reg;
  logic [ACC_W-1:0] acc_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             in_ready_reg;

  logic             take;
  logic             room;
  logic             fifo_push;
  logic             fifo_empty;
  logic             fifo_full_int;

  assign take = in_valid && in_ready_reg;

  // Room when not full, or when the head leaves in the same cycle.
  assign room      = !fifo_full_int || (out_ready && !fifo_empty);
  assign fifo_push = (state_reg == PUSH) && room;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      in_ready_reg <= 1'b1;
    end else if (clear) begin
      state_reg    <= IDLE;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      in_ready_reg <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (take) begin
            acc_reg   <= ACC_W'(in_sum);
            cnt_reg   <= CNT_W'(1);
            state_reg <= ACCUM;
          end
        end
        ACCUM: begin
          if (take) begin
            acc_reg <= acc_reg + ACC_W'(in_sum);
            if (cnt_reg == LAST_CNT) begin
              // Block complete: counter wraps and intake pauses for the push.
              cnt_reg      <= '0;
              state_reg    <= PUSH;
              in_ready_reg <= 1'b0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        PUSH: begin
          if (room) begin
            acc_reg      <= '0;
            state_reg    <= IDLE;
            in_ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg    <= IDLE;
          acc_reg      <= '0;
          cnt_reg      <= '0;
          in_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  sum_collector_fifo #(
    .DEPTH (DEPTH),
    .ACC_W (ACC_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .push      (fifo_push),
    .push_data (acc_reg),
    .pop       (out_ready),
    .pop_data  (out_data),
    .full      (fifo_full_int),
    .empty     (fifo_empty)
  );

  assign in_ready  = in_ready_reg;
  assign out_valid = !fifo_empty;
  assign blk_cnt   = cnt_reg;
  assign fifo_full = fifo_full_int;

endmodule
